// File: rtl/pll_ctrl_pkg.sv
// Shared types and default 50 MHz timing for the video PLL lock/reset controller.
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 500000;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_CNT_W          = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous status inputs.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // two-stage capture; both stages clear on reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, qualifies lock, releases sys_rst, retries on timeout/loss.
// Define PLL_LOSS_FILTER_EN to ignore single-cycle lock dropouts while in RUN.
module pll_lock_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] loss_count
);

  localparam int TMR_W = $clog2(max3(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES) + 1);

  // Reload values are "cycles minus one" so each state lasts exactly its parameter.
  localparam logic [TMR_W-1:0] LOAD_RST = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOAD_TO  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOAD_ST  = TMR_W'(STABLE_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]   loss_q, loss_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;
  logic               lk_s;
  logic               loss_s;

  sync_2ff u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lk_s)
  );

`ifdef PLL_LOSS_FILTER_EN
  logic lk_prev_q;

  // previous synchronised lock sample, so a loss needs two low samples in a row
  always_ff @(posedge refclk) begin
    if (rst) begin
      lk_prev_q <= 1'b0;
    end else begin
      lk_prev_q <= lk_s;
    end
  end

  assign loss_s = ~lk_s & ~lk_prev_q;
`else
  assign loss_s = ~lk_s;
`endif

  // state, shared timer, counters and registered outputs
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= PLL_RESET;
      tmr_q     <= LOAD_RST;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
    end
  end

  // next-state logic; outputs derive from the next state so they move with the state register
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      PLL_RESET: begin
        if (tmr_q == '0) begin
          state_d = WAIT_LOCK;
          tmr_d   = LOAD_TO;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      WAIT_LOCK: begin
        // lock is checked before expiry so a coincident lock wins over the retry
        if (lk_s) begin
          state_d = STABLE;
          tmr_d   = LOAD_ST;
        end else if (tmr_q == '0) begin
          state_d = PLL_RESET;
          tmr_d   = LOAD_RST;
          retry_d = sat_inc(retry_q);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      STABLE: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          tmr_d   = LOAD_TO;
        end else if (tmr_q == '0) begin
          state_d = RUN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      RUN: begin
        if (loss_s) begin
          state_d = PLL_RESET;
          tmr_d   = LOAD_RST;
          loss_d  = sat_inc(loss_q);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = PLL_RESET;
        tmr_d   = LOAD_RST;
      end
    endcase
    pll_rst_d = (state_d == PLL_RESET);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Directed bench for pll_lock_reset_ctrl: vector table for the retry/saturation trace plus timed sequences.
module tb_pll_lock_reset_ctrl;

  localparam int P_RST = 4;
  localparam int P_TO  = 20;
  localparam int P_ST  = 8;
  localparam int P_CW  = 2;

  logic            refclk = 1'b0;
  logic            rst = 1'b1;
  logic            pll_locked = 1'b0;
  logic            pll_rst;
  logic            sys_rst;
  logic            ready;
  logic [P_CW-1:0] retry_count;
  logic [P_CW-1:0] loss_count;

  int n_tests = 0;
  int n_fail  = 0;

  pll_lock_reset_ctrl #(
    .PLL_RST_CYCLES (P_RST),
    .LOCK_TIMEOUT   (P_TO),
    .STABLE_CYCLES  (P_ST),
    .CNT_W          (P_CW)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .retry_count (retry_count),
    .loss_count  (loss_count)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic rst;
    logic lock;
    int   cycles;
    int   e_prst;
    int   e_srst;
    int   e_rdy;
    int   e_rty;
    int   e_los;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int prst, input int srst, input int rdy,
                         input int rty, input int los);
    chk({tag, ".pll_rst"}, int'(pll_rst), prst);
    chk({tag, ".sys_rst"}, int'(sys_rst), srst);
    chk({tag, ".ready"}, int'(ready), rdy);
    chk({tag, ".retry"}, int'(retry_count), rty);
    chk({tag, ".loss"}, int'(loss_count), los);
  endtask

  // Count consecutive high samples of pll_rst starting at the current sample.
  task automatic count_prst(input string name, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (!pll_rst) break;
      n++;
      step(1);
    end
    chk(name, n, exp);
  endtask

  task automatic wait_ready(input string name, input int want, input int budget);
    int n;
    n = 0;
    while (int'(ready) != want && n < budget) begin
      step(1);
      n++;
    end
    chk(name, int'(ready), want);
  endtask

  initial begin
    // Lock never arrives: 4-cycle pll_rst, 20-cycle wait, retry saturating at 3.
    tbl[0]  = '{1'b1, 1'b0,  2, 1, 1, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0,  3, 1, 1, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0,  1, 0, 1, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 19, 0, 1, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b0,  1, 1, 1, 0, 1, 0};
    tbl[5]  = '{1'b0, 1'b0,  3, 1, 1, 0, 1, 0};
    tbl[6]  = '{1'b0, 1'b0,  1, 0, 1, 0, 1, 0};
    tbl[7]  = '{1'b0, 1'b0, 20, 1, 1, 0, 2, 0};
    tbl[8]  = '{1'b0, 1'b0, 24, 1, 1, 0, 3, 0};
    tbl[9]  = '{1'b0, 1'b0, 24, 1, 1, 0, 3, 0};
    tbl[10] = '{1'b0, 1'b0,  4, 0, 1, 0, 3, 0};
    tbl[11] = '{1'b0, 1'b0, 19, 0, 1, 0, 3, 0};

    for (int i = 0; i < 12; i++) begin
      rst        = tbl[i].rst;
      pll_locked = tbl[i].lock;
      step(tbl[i].cycles);
      chk_all($sformatf("vec%0d", i), tbl[i].e_prst, tbl[i].e_srst, tbl[i].e_rdy,
              tbl[i].e_rty, tbl[i].e_los);
    end

    // Normal bring-up: lock rises 2 cycles after pll_rst falls.
    rst = 1'b1;
    step(1);
    chk_all("reset", 1, 1, 0, 0, 0);
    rst = 1'b0;
    count_prst("bringup.prst_len", P_RST);
    step(2);
    pll_locked = 1'b1;
    step(10);
    chk("bringup.sys_rst_held", int'(sys_rst), 1);
    step(1);
    chk_all("bringup.run", 0, 0, 1, 0, 0);

    // One-cycle dropout in RUN.
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    chk("drop1.not_yet", int'(sys_rst), 0);
    step(1);
`ifdef PLL_LOSS_FILTER_EN
    chk_all("drop1.ignored", 0, 0, 1, 0, 0);
    step(3);
    chk_all("drop1.still_run", 0, 0, 1, 0, 0);
    // Two-cycle dropout is a real loss, seen on the 4th edge.
    pll_locked = 1'b0;
    step(2);
    pll_locked = 1'b1;
    step(1);
    chk("drop2.not_yet", int'(sys_rst), 0);
    step(1);
    chk_all("drop2.loss", 1, 1, 0, 0, 1);
    count_prst("drop2.prst_len", P_RST);
`else
    chk_all("drop1.loss", 1, 1, 0, 0, 1);
    count_prst("drop1.prst_len", P_RST);
`endif
    step(8);
    chk("relock.sys_rst_held", int'(sys_rst), 1);
    step(1);
    chk_all("relock.run", 0, 0, 1, 0, 1);

    // Second loss, then a one-cycle rst in RUN clears everything.
    pll_locked = 1'b0;
    step(2);
    pll_locked = 1'b1;
    wait_ready("loss2.leave_run", 0, 10);
    wait_ready("loss2.back_run", 1, 40);
    chk("loss2.count", int'(loss_count), 2);
    rst = 1'b1;
    step(1);
    chk_all("rst_in_run", 1, 1, 0, 0, 0);
    rst = 1'b0;
    count_prst("rst_in_run.prst_len", P_RST);
    step(8);
    chk("rst_in_run.sys_rst_held", int'(ready), 0);
    step(1);
    chk_all("rst_in_run.run", 0, 0, 1, 0, 0);

    // Dropout at stable count 5 restarts the full stable window.
    pll_locked = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(4);
    pll_locked = 1'b1;
    step(5);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(5);
    chk_all("stable_abort.no_early_run", 0, 1, 0, 0, 0);
    step(5);
    chk_all("stable_abort.held", 0, 1, 0, 0, 0);
    step(1);
    chk_all("stable_abort.run", 0, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
